axi3_wr_slave: RTL and testbench

//  Parametrised AXI3 write-path slave. Queues write addresses, absorbs W bursts (FIXED/INCR/WRAP) into an

---
 rtl/axi_pkg.sv | 36 +++
 rtl/axi_sync_fifo.sv | 48 ++++
 rtl/axi3_wr_slave.sv | 193 +++++++++++++++++++
 tb/tb_axi3_wr_slave.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared types for the AXI3 write slave: burst/response codes, AW request payload, FSM states.
package axi_pkg;

   // Maximum field widths carried in the AW payload; top-level parameters must not exceed these.
   localparam int unsigned AXI_ID_MAX_W   = 16;
   localparam int unsigned AXI_ADDR_MAX_W = 64;
   localparam int unsigned AXI_LEN_MAX_W  = 8;

   typedef enum logic [1:0] {
      FIXED = 2'd0,
      INCR  = 2'd1,
      WRAP  = 2'd2
   } burst_e;

   typedef enum logic [1:0] {
      OKAY   = 2'd0,
      EXOKAY = 2'd1,
      SLVERR = 2'd2,
      DECERR = 2'd3
   } resp_e;

   typedef struct packed {
      logic [AXI_ID_MAX_W-1:0]   id;
      logic [AXI_ADDR_MAX_W-1:0] addr;
      logic [AXI_LEN_MAX_W-1:0]  len;
      logic [2:0]                size;
      burst_e                    burst;
   } aw_req_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      RESP = 2'd2
   } state_e;

endpackage

// File: rtl/axi_sync_fifo.sv
// Show-ahead synchronous FIFO with full/empty flags and same-cycle push/pop.
module axi_sync_fifo #(
   parameter type         T     = logic [7:0],
   parameter int unsigned DEPTH = 4
) (
   input  logic aclk,
   input  logic arst,
   input  logic push,
   input  T     din,
   input  logic pop,
   output T     dout,
   output logic full,
   output logic empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   T                 mem [DEPTH];
   logic [PTR_W:0]   wr_ptr;
   logic [PTR_W:0]   rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Extra pointer MSB distinguishes full from empty when the index bits match.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                    (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr[PTR_W-1:0]];

   // Pointer update; reset empties the queue.
   always_ff @(posedge aclk) begin
      if (arst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      end
   end

   // Storage write, no reset needed on payload.
   always_ff @(posedge aclk) begin
      if (do_push) mem[wr_ptr[PTR_W-1:0]] <= din;
   end

endmodule

// File: rtl/axi3_wr_slave.sv
// AXI3 write-path slave: queued AW, FIXED/INCR/WRAP bursts into a byte-strobed memory, per-burst B.
module axi3_wr_slave
   import axi_pkg::*;
#(
   parameter int unsigned               ID_W      = 4,
   parameter int unsigned               ADDR_W    = 32,
   parameter int unsigned               DATA_W    = 32,
   parameter int unsigned               LEN_W     = 4,
   parameter int unsigned               MEM_WORDS = 1024,
   parameter logic [AXI_ADDR_MAX_W-1:0] BASE_ADDR = '0,
   parameter int unsigned               AW_DEPTH  = 4
) (
   input  logic                         aclk,
   input  logic                         arst,
   input  logic [ID_W-1:0]              awid,
   input  logic [ADDR_W-1:0]            awaddr,
   input  logic [LEN_W-1:0]             awlen,
   input  logic [2:0]                   awsize,
   input  logic [1:0]                   awbrust,
   input  logic                         awvalid,
   output logic                         awready,
   input  logic [ID_W-1:0]              wid,
   input  logic [DATA_W-1:0]            wdata,
   input  logic [DATA_W/8-1:0]          wstrob,
   input  logic                         wlast,
   input  logic                         wvalid,
   output logic                         wready,
   output logic [ID_W-1:0]              bid,
   output logic [1:0]                   bresp,
   output logic                         bvalid,
   input  logic                         bready,
   input  logic [$clog2(MEM_WORDS)-1:0] dbg_idx,
   output logic [DATA_W-1:0]            dbg_data
);

   localparam int unsigned STRB_W  = DATA_W / 8;
   localparam int unsigned BYTE_SH = $clog2(STRB_W);
   localparam int unsigned IDX_W   = $clog2(MEM_WORDS);
   localparam logic [AXI_ADDR_MAX_W-1:0] A_ONE = AXI_ADDR_MAX_W'(1);

   state_e                    state;
   aw_req_t                   aw_in;
   aw_req_t                   aw_head;
   aw_req_t                   cur;
   logic                      q_full;
   logic                      q_empty;
   logic                      q_pop;
   logic [AXI_LEN_MAX_W-1:0]  beat_cnt;
   logic                      dec_err;
   logic                      slv_err;

   logic                      beat;
   logic [AXI_ADDR_MAX_W-1:0] offs;
   logic [AXI_ADDR_MAX_W-1:0] word;
   logic                      in_range;
   logic [IDX_W-1:0]          wr_idx;
   logic [AXI_ADDR_MAX_W-1:0] incr;
   logic [AXI_ADDR_MAX_W-1:0] lin_next;
   logic [AXI_ADDR_MAX_W-1:0] wrap_mask;
   logic [AXI_ADDR_MAX_W-1:0] next_addr;
   logic                      cfg_err;
   logic                      last_beat;
   logic                      beat_slv;
   logic                      dec_n;
   logic                      slv_n;
   logic                      done;
   resp_e                     resp_n;

   logic [DATA_W-1:0]         mem [MEM_WORDS];

   assign awready  = !arst && !q_full;
   assign q_pop    = (state == IDLE) && !q_empty;
   assign beat     = (state == DATA) && wvalid && wready;
   assign dbg_data = mem[dbg_idx];

   // Widen the incoming AW fields into the queue payload.
   always_comb begin
      aw_in       = '0;
      aw_in.id    = AXI_ID_MAX_W'(awid);
      aw_in.addr  = AXI_ADDR_MAX_W'(awaddr);
      aw_in.len   = AXI_LEN_MAX_W'(awlen);
      aw_in.size  = awsize;
      aw_in.burst = burst_e'(awbrust);
   end

   axi_sync_fifo #(
      .T     (aw_req_t),
      .DEPTH (AW_DEPTH)
   ) u_aw_q (
      .aclk  (aclk),
      .arst  (arst),
      .push  (awvalid && awready),
      .din   (aw_in),
      .pop   (q_pop),
      .dout  (aw_head),
      .full  (q_full),
      .empty (q_empty)
   );

   // Address decode, next-address generation and per-beat error evaluation.
   always_comb begin
      offs      = cur.addr - BASE_ADDR;
      word      = offs >> BYTE_SH;
      in_range  = (word < AXI_ADDR_MAX_W'(MEM_WORDS));
      wr_idx    = IDX_W'(word);
      incr      = A_ONE << cur.size;
      lin_next  = (cur.addr & ~(incr - A_ONE)) + incr;
      wrap_mask = ((AXI_ADDR_MAX_W'(cur.len) + A_ONE) << cur.size) - A_ONE;

      cfg_err   = (cur.size > 3'(BYTE_SH));
      next_addr = cur.addr;
      case (cur.burst)
         FIXED: next_addr = cur.addr;
         INCR:  next_addr = lin_next;
         WRAP: begin
            next_addr = (cur.addr & ~wrap_mask) | (lin_next & wrap_mask);
            if ((cur.len != AXI_LEN_MAX_W'(1)) && (cur.len != AXI_LEN_MAX_W'(3)) &&
                (cur.len != AXI_LEN_MAX_W'(7)) && (cur.len != AXI_LEN_MAX_W'(15)))
               cfg_err = 1'b1;
         end
         default: cfg_err = 1'b1;
      endcase

      last_beat = (beat_cnt == cur.len);
      beat_slv  = (cur.id != AXI_ID_MAX_W'(wid)) || cfg_err || (last_beat != wlast);
      dec_n     = dec_err || !in_range;
      slv_n     = slv_err || beat_slv;
      done      = last_beat || wlast;
      if (dec_n)      resp_n = DECERR;
      else if (slv_n) resp_n = SLVERR;
      else            resp_n = OKAY;
   end

   // Byte-lane memory write on each in-range W handshake; contents survive reset.
   always_ff @(posedge aclk) begin
      if (!arst && beat && in_range) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (wstrob[b]) mem[wr_idx][b*8 +: 8] <= wdata[b*8 +: 8];
         end
      end
   end

   // Burst FSM with registered wready/bvalid/bid/bresp.
   always_ff @(posedge aclk) begin
      if (arst) begin
         state    <= IDLE;
         cur      <= '0;
         beat_cnt <= '0;
         dec_err  <= 1'b0;
         slv_err  <= 1'b0;
         wready   <= 1'b0;
         bvalid   <= 1'b0;
         bid      <= '0;
         bresp    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!q_empty) begin
                  cur      <= aw_head;
                  beat_cnt <= '0;
                  dec_err  <= 1'b0;
                  slv_err  <= 1'b0;
                  wready   <= 1'b1;
                  state    <= DATA;
               end
            end
            DATA: begin
               if (beat) begin
                  dec_err  <= dec_n;
                  slv_err  <= slv_n;
                  cur.addr <= next_addr;
                  beat_cnt <= beat_cnt + AXI_LEN_MAX_W'(1);
                  if (done) begin
                     wready <= 1'b0;
                     bvalid <= 1'b1;
                     bid    <= ID_W'(cur.id);
                     bresp  <= resp_n;
                     state  <= RESP;
                  end
               end
            end
            RESP: begin
               if (bready) begin
                  bvalid <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi3_wr_slave.sv
// Directed self-checking bench for axi3_wr_slave (default parameters).
module tb_axi3_wr_slave;

   logic        aclk = 1'b0;
   logic        arst;
   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [3:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awbrust;
   logic        awvalid;
   logic        awready;
   logic [3:0]  wid;
   logic [31:0] wdata;
   logic [3:0]  wstrob;
   logic        wlast;
   logic        wvalid;
   logic        wready;
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [9:0]  dbg_idx;
   logic [31:0] dbg_data;

   int checks = 0;
   int errors = 0;

   always #5 aclk = ~aclk;

   axi3_wr_slave dut (
      .aclk     (aclk),
      .arst     (arst),
      .awid     (awid),
      .awaddr   (awaddr),
      .awlen    (awlen),
      .awsize   (awsize),
      .awbrust  (awbrust),
      .awvalid  (awvalid),
      .awready  (awready),
      .wid      (wid),
      .wdata    (wdata),
      .wstrob   (wstrob),
      .wlast    (wlast),
      .wvalid   (wvalid),
      .wready   (wready),
      .bid      (bid),
      .bresp    (bresp),
      .bvalid   (bvalid),
      .bready   (bready),
      .dbg_idx  (dbg_idx),
      .dbg_data (dbg_data)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                     input logic [2:0] size, input logic [1:0] burst);
      int n = 0;
      @(negedge aclk);
      awid = id; awaddr = addr; awlen = len; awsize = size; awbrust = burst; awvalid = 1'b1;
      while (!awready && n < 50) begin
         @(negedge aclk);
         n++;
      end
      if (!awready) chk("aw_timeout", 64'(awready), 64'd1);
      @(posedge aclk);
      #1 awvalid = 1'b0;
   endtask

   task automatic wbeat(input logic [3:0] id, input logic [31:0] data, input logic [3:0] strb,
                        input logic last);
      int n = 0;
      @(negedge aclk);
      wid = id; wdata = data; wstrob = strb; wlast = last; wvalid = 1'b1;
      while (!wready && n < 50) begin
         @(negedge aclk);
         n++;
      end
      if (!wready) chk("w_timeout", 64'(wready), 64'd1);
      @(posedge aclk);
      #1 begin wvalid = 1'b0; wlast = 1'b0; end
   endtask

   task automatic get_b(input string tag, input logic [3:0] id, input logic [1:0] resp);
      int n = 0;
      @(negedge aclk);
      while (!bvalid && n < 50) begin
         @(negedge aclk);
         n++;
      end
      chk({tag, "_bvalid"}, 64'(bvalid), 64'd1);
      chk({tag, "_bid"}, 64'(bid), 64'(id));
      chk({tag, "_bresp"}, 64'(bresp), 64'(resp));
      bready = 1'b1;
      @(posedge aclk);
      #1 bready = 1'b0;
   endtask

   task automatic mem_chk(input string tag, input logic [9:0] idx, input logic [31:0] exp);
      dbg_idx = idx;
      #1 chk(tag, 64'(dbg_data), 64'(exp));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      arst = 1'b1;
      awid = '0; awaddr = '0; awlen = '0; awsize = '0; awbrust = '0; awvalid = 1'b0;
      wid = '0; wdata = '0; wstrob = '0; wlast = 1'b0; wvalid = 1'b0;
      bready = 1'b0; dbg_idx = '0;

      // Reset state
      repeat (3) @(negedge aclk);
      chk("rst_awready", 64'(awready), 64'd0);
      chk("rst_wready", 64'(wready), 64'd0);
      chk("rst_bvalid", 64'(bvalid), 64'd0);
      chk("rst_bid", 64'(bid), 64'd0);
      chk("rst_bresp", 64'(bresp), 64'd0);
      arst = 1'b0;
      @(negedge aclk);
      chk("post_rst_awready", 64'(awready), 64'd1);

      // 1 INCR with wready latency
      aw(4'd3, 32'h10, 4'd3, 3'd2, 2'd1);
      @(negedge aclk);
      chk("lat_wready_n1", 64'(wready), 64'd0);
      @(negedge aclk);
      chk("lat_wready_n2", 64'(wready), 64'd1);
      for (int i = 0; i < 4; i++) wbeat(4'd3, 32'hA0 + 32'(i), 4'hF, i == 3);
      get_b("incr", 4'd3, 2'd0);
      mem_chk("incr_m4", 10'd4, 32'hA0);
      mem_chk("incr_m5", 10'd5, 32'hA1);
      mem_chk("incr_m6", 10'd6, 32'hA2);
      mem_chk("incr_m7", 10'd7, 32'hA3);

      // 2 WRAP
      aw(4'd5, 32'h38, 4'd3, 3'd2, 2'd2);
      for (int i = 0; i < 4; i++) wbeat(4'd5, 32'hB0 + 32'(i), 4'hF, i == 3);
      get_b("wrap", 4'd5, 2'd0);
      mem_chk("wrap_mE", 10'h0E, 32'hB0);
      mem_chk("wrap_mF", 10'h0F, 32'hB1);
      mem_chk("wrap_mC", 10'h0C, 32'hB2);
      mem_chk("wrap_mD", 10'h0D, 32'hB3);

      // 3 FIXED with partial strobes
      aw(4'd1, 32'h0, 4'd1, 3'd2, 2'd0);
      wbeat(4'd1, 32'h11112222, 4'b0011, 1'b0);
      wbeat(4'd1, 32'h33334444, 4'b1100, 1'b1);
      get_b("fixed", 4'd1, 2'd0);
      mem_chk("fixed_m0", 10'd0, 32'h33332222);

      // 4a wid mismatch
      aw(4'd2, 32'h20, 4'd0, 3'd2, 2'd1);
      wbeat(4'd7, 32'hDEAD, 4'hF, 1'b1);
      get_b("widmis", 4'd2, 2'd2);

      // 4b out of range: one past the last word, must not alias onto word 0
      aw(4'd4, 32'h1000, 4'd0, 3'd2, 2'd1);
      wbeat(4'd4, 32'hBAD0BAD0, 4'hF, 1'b1);
      get_b("decerr", 4'd4, 2'd3);
      mem_chk("decerr_m0", 10'd0, 32'h33332222);

      // 4c early wlast: B right after beat 1
      aw(4'd6, 32'h40, 4'd3, 3'd2, 2'd1);
      wbeat(4'd6, 32'hC0DE0000, 4'hF, 1'b0);
      wbeat(4'd6, 32'hC0DE0001, 4'hF, 1'b1);
      @(negedge aclk);
      chk("trunc_bvalid_next", 64'(bvalid), 64'd1);
      chk("trunc_wready_low", 64'(wready), 64'd0);
      get_b("trunc", 4'd6, 2'd2);
      mem_chk("trunc_m11", 10'h11, 32'hC0DE0001);

      // 4d oversize beat and illegal WRAP length still consume len+1 beats
      aw(4'd8, 32'h80, 4'd1, 3'd3, 2'd1);
      wbeat(4'd8, 32'h1, 4'hF, 1'b0);
      wbeat(4'd8, 32'h2, 4'hF, 1'b1);
      get_b("oversize", 4'd8, 2'd2);
      aw(4'd9, 32'h100, 4'd2, 3'd2, 2'd2);
      for (int i = 0; i < 3; i++) wbeat(4'd9, 32'h9 + 32'(i), 4'hF, i == 2);
      get_b("wraplen", 4'd9, 2'd2);

      // 5 Queue fill with bready low, in-order B
      for (int i = 0; i < 5; i++) aw(4'hA + 4'(i), 32'h180 + 32'(i*4), 4'd0, 3'd2, 2'd1);
      @(negedge aclk);
      chk("q_full_awready", 64'(awready), 64'd0);
      for (int i = 0; i < 5; i++) begin
         wbeat(4'hA + 4'(i), 32'hC0 + 32'(i), 4'hF, 1'b1);
         if (i == 0) begin
            repeat (3) @(negedge aclk);
            chk("hold_bvalid", 64'(bvalid), 64'd1);
            chk("hold_bid", 64'(bid), 64'hA);
         end
         get_b("order", 4'hA + 4'(i), 2'd0);
      end
      @(negedge aclk);
      chk("q_drain_awready", 64'(awready), 64'd1);
      mem_chk("order_m60", 10'h60, 32'hC0);
      mem_chk("order_m64", 10'h64, 32'hC4);

      // 6 Reset mid-burst
      aw(4'hF, 32'h200, 4'd3, 3'd2, 2'd1);
      wbeat(4'hF, 32'hE0, 4'hF, 1'b0);
      wbeat(4'hF, 32'hE1, 4'hF, 1'b0);
      @(negedge aclk);
      arst = 1'b1;
      @(negedge aclk);
      chk("mid_rst_awready", 64'(awready), 64'd0);
      chk("mid_rst_wready", 64'(wready), 64'd0);
      chk("mid_rst_bvalid", 64'(bvalid), 64'd0);
      chk("mid_rst_bid", 64'(bid), 64'd0);
      chk("mid_rst_bresp", 64'(bresp), 64'd0);
      arst = 1'b0;
      repeat (4) @(negedge aclk);
      chk("post_rst_no_b", 64'(bvalid), 64'd0);
      chk("post_rst_no_w", 64'(wready), 64'd0);
      mem_chk("retain_m80", 10'h80, 32'hE0);
      mem_chk("retain_m81", 10'h81, 32'hE1);
      aw(4'd1, 32'h300, 4'd0, 3'd2, 2'd1);
      wbeat(4'd1, 32'h5A5A5A5A, 4'hF, 1'b1);
      get_b("after_rst", 4'd1, 2'd0);
      mem_chk("after_rst_mC0", 10'hC0, 32'h5A5A5A5A);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
